// File: rtl/dynamixel_status_rx.sv
// Dynamixel Protocol 1.0 status packet receiver (8N1 UART + parser).
// Optional stats counters: define DXL_RX_STATS_EN.
module dynamixel_status_rx #(
  parameter int CLK_HZ         = 50000000,
  parameter int BAUD           = 1000000,
  parameter int MAX_PARAMS     = 4,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic        rx_enable,
  input  logic [7:0]  expected_id,
  output logic        status_valid,
  output logic [7:0]  status_id,
  output logic [7:0]  status_error,
  output logic [31:0] status_params,
  output logic [2:0]  status_nparams,
  output logic        chk_err,
  output logic        pkt_err,
  output logic        timeout,
  output logic        busy
`ifdef DXL_RX_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] err_cnt
`endif
);

  localparam int DIV    = CLK_HZ / BAUD;
  localparam int HALF   = DIV / 2;
  localparam int CW     = $clog2(DIV + 1);
  localparam int TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam int MAXLEN = MAX_PARAMS + 2;

  typedef enum logic [1:0] {
    U_IDLE, U_START, U_DATA, U_STOP
  } ust_e;

  typedef enum logic [2:0] {
    P_HDR1, P_HDR2, P_ID, P_LEN,
    P_ERR, P_PARAM, P_CHK
  } pst_e;

  logic          sy1_q, sy2_q, sy3_q;
  ust_e          ust_q, ust_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          byte_stb, frm_err;

  pst_e          pst_q, pst_d;
  logic [7:0]    id_q, id_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    err_q, err_d;
  logic [31:0]   par_q, par_d;
  logic [2:0]    k_q, k_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] idle_q, idle_d;

  logic          sv_q, sv_d;
  logic          ce_q, ce_d;
  logic          pe_q, pe_d;
  logic          to_q, to_d;
  logic [7:0]    sid_q, sid_d;
  logic [7:0]    serr_q, serr_d;
  logic [31:0]   spar_q, spar_d;
  logic [2:0]    snp_q, snp_d;

  logic [2:0]    np;
  assign np = len_q[2:0] - 3'd2;

  // two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      sy1_q <= 1'b1;
      sy2_q <= 1'b1;
      sy3_q <= 1'b1;
    end else begin
      sy1_q <= rxd;
      sy2_q <= sy1_q;
      sy3_q <= sy2_q;
    end
  end

  // UART bit timing: start re-check at half bit, data/stop at mid-bit
  always_comb begin
    ust_d    = ust_q;
    cnt_d    = cnt_q + 1'b1;
    bit_d    = bit_q;
    sh_d     = sh_q;
    byte_stb = 1'b0;
    frm_err  = 1'b0;
    if (!rx_enable) begin
      ust_d = U_IDLE;
      cnt_d = '0;
    end else begin
      unique case (ust_q)
        U_IDLE: begin
          cnt_d = '0;
          if (!sy2_q && sy3_q) ust_d = U_START;
        end
        U_START: begin
          if (cnt_q == CW'(HALF - 1)) begin
            cnt_d = '0;
            bit_d = '0;
            ust_d = sy2_q ? U_IDLE : U_DATA;
          end
        end
        U_DATA: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            sh_d  = {sy2_q, sh_q[7:1]};
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'd7) ust_d = U_STOP;
          end
        end
        U_STOP: begin
          if (cnt_q == CW'(DIV - 1)) begin
            cnt_d = '0;
            ust_d = U_IDLE;
            if (sy2_q) byte_stb = 1'b1;
            else frm_err = 1'b1;
          end
        end
      endcase
    end
  end

  // packet parser, checksum, timeout and result registers
  always_comb begin
    pst_d  = pst_q;
    id_d   = id_q;
    len_d  = len_q;
    err_d  = err_q;
    par_d  = par_q;
    k_d    = k_q;
    sum_d  = sum_q;
    idle_d = idle_q;
    sv_d   = 1'b0;
    ce_d   = 1'b0;
    pe_d   = 1'b0;
    to_d   = 1'b0;
    sid_d  = sid_q;
    serr_d = serr_q;
    spar_d = spar_q;
    snp_d  = snp_q;
    if (!rx_enable) begin
      pst_d  = P_HDR1;
      idle_d = '0;
    end else if (frm_err) begin
      pe_d   = 1'b1;
      pst_d  = P_HDR1;
      idle_d = '0;
    end else if (byte_stb) begin
      idle_d = '0;
      unique case (pst_q)
        P_HDR1: if (sh_q == 8'hFF) pst_d = P_HDR2;
        P_HDR2: pst_d = (sh_q == 8'hFF) ? P_ID : P_HDR1;
        P_ID: begin
          if (sh_q != 8'hFF) begin
            id_d  = sh_q;
            sum_d = sh_q;
            pst_d = P_LEN;
          end
        end
        P_LEN: begin
          if (sh_q >= 8'd2 && sh_q <= 8'(MAXLEN)) begin
            len_d = sh_q;
            sum_d = sum_q + sh_q;
            par_d = '0;
            k_d   = '0;
            pst_d = P_ERR;
          end else begin
            pe_d  = 1'b1;
            pst_d = P_HDR1;
          end
        end
        P_ERR: begin
          err_d = sh_q;
          sum_d = sum_q + sh_q;
          pst_d = (len_q > 8'd2) ? P_PARAM : P_CHK;
        end
        P_PARAM: begin
          par_d[{k_q[1:0], 3'b000} +: 8] = sh_q;
          sum_d = sum_q + sh_q;
          k_d   = k_q + 3'd1;
          if (k_q + 3'd1 == np) pst_d = P_CHK;
        end
        P_CHK: begin
          pst_d = P_HDR1;
          if (sh_q == ~sum_q) begin
            if (id_q == expected_id) begin
              sv_d   = 1'b1;
              sid_d  = id_q;
              serr_d = err_q;
              spar_d = par_q;
              snp_d  = np;
            end
          end else begin
            ce_d = 1'b1;
          end
        end
        default: pst_d = P_HDR1;
      endcase
    end else if (pst_q != P_HDR1 && ust_q == U_IDLE) begin
      if (idle_q == TW'(TIMEOUT_CYCLES - 1)) begin
        to_d   = 1'b1;
        pst_d  = P_HDR1;
        idle_d = '0;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else if (pst_q == P_HDR1) begin
      idle_d = '0;
    end
  end

  // state and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ust_q  <= U_IDLE;
      cnt_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      pst_q  <= P_HDR1;
      id_q   <= '0;
      len_q  <= '0;
      err_q  <= '0;
      par_q  <= '0;
      k_q    <= '0;
      sum_q  <= '0;
      idle_q <= '0;
      sv_q   <= 1'b0;
      ce_q   <= 1'b0;
      pe_q   <= 1'b0;
      to_q   <= 1'b0;
      sid_q  <= '0;
      serr_q <= '0;
      spar_q <= '0;
      snp_q  <= '0;
    end else begin
      ust_q  <= ust_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      pst_q  <= pst_d;
      id_q   <= id_d;
      len_q  <= len_d;
      err_q  <= err_d;
      par_q  <= par_d;
      k_q    <= k_d;
      sum_q  <= sum_d;
      idle_q <= idle_d;
      sv_q   <= sv_d;
      ce_q   <= ce_d;
      pe_q   <= pe_d;
      to_q   <= to_d;
      sid_q  <= sid_d;
      serr_q <= serr_d;
      spar_q <= spar_d;
      snp_q  <= snp_d;
    end
  end

  assign status_valid   = sv_q;
  assign status_id      = sid_q;
  assign status_error   = serr_q;
  assign status_params  = spar_q;
  assign status_nparams = snp_q;
  assign chk_err        = ce_q;
  assign pkt_err        = pe_q;
  assign timeout        = to_q;
  assign busy           = (pst_q != P_HDR1);

`ifdef DXL_RX_STATS_EN
  logic [15:0] good_q, errc_q;

  // saturating good/error packet counters
  always_ff @(posedge clk) begin
    if (reset) begin
      good_q <= '0;
      errc_q <= '0;
    end else begin
      if (sv_q && good_q != 16'hFFFF)
        good_q <= good_q + 16'd1;
      if ((ce_q | pe_q | to_q) && errc_q != 16'hFFFF)
        errc_q <= errc_q + 16'd1;
    end
  end

  assign good_cnt = good_q;
  assign err_cnt  = errc_q;
`endif

endmodule

// File: tb/tb_dynamixel_status_rx.sv
// Testbench for dynamixel_status_rx: directed plus randomized packets
// checked against a packet-level reference model.
module tb_dynamixel_status_rx;

  localparam int DIV = 50;
  localparam int LAT = DIV * 19 / 2;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          kind;
    logic [7:0]  id;
    logic [7:0]  err;
    logic [31:0] par;
    logic [2:0]  np;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rxd = 1'b1;
  logic        rx_enable = 1'b1;
  logic [7:0]  expected_id = 8'h01;
  logic        status_valid;
  logic [7:0]  status_id;
  logic [7:0]  status_error;
  logic [31:0] status_params;
  logic [2:0]  status_nparams;
  logic        chk_err, pkt_err, timeout, busy;
`ifdef DXL_RX_STATS_EN
  logic [15:0] good_cnt, err_cnt;
`endif

  dynamixel_status_rx dut (
    .clk(clk),
    .reset(reset),
    .rxd(rxd),
    .rx_enable(rx_enable),
    .expected_id(expected_id),
    .status_valid(status_valid),
    .status_id(status_id),
    .status_error(status_error),
    .status_params(status_params),
    .status_nparams(status_nparams),
    .chk_err(chk_err),
    .pkt_err(pkt_err),
    .timeout(timeout),
`ifdef DXL_RX_STATS_EN
    .good_cnt(good_cnt),
    .err_cnt(err_cnt),
`endif
    .busy(busy)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_valid = 0, n_chk = 0, n_pkt = 0, n_to = 0;
  int n_busy = 0, n_multi = 0;
  int last_valid_cyc = 0, last_pkt_cyc = 0, last_to_cyc = 0;
  int last_start = 0;

  always @(negedge clk) begin
    if (status_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
    end
    if (chk_err) n_chk++;
    if (pkt_err) begin
      n_pkt++;
      last_pkt_cyc = cyc;
    end
    if (timeout) begin
      n_to++;
      last_to_cyc = cyc;
    end
    if (busy) n_busy++;
    if (int'(chk_err) + int'(pkt_err) + int'(timeout) > 1)
      n_multi++;
  end

  int checks = 0, fails = 0;
  logic [7:0]  m_id = 0, m_err = 0;
  logic [31:0] m_par = 0;
  logic [2:0]  m_np = 0;
  int v0, c0, p0, t0, b0;

  task automatic snap();
    v0 = n_valid; c0 = n_chk; p0 = n_pkt;
    t0 = n_to; b0 = n_busy;
  endtask

  task automatic send_byte(input logic [7:0] b,
                           input logic stopv);
    @(negedge clk);
    rxd = 1'b0;
    last_start = cyc;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (DIV) @(negedge clk);
    end
    rxd = stopv;
    repeat (DIV) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic send_pkt(input bq_t q, input logic bad_last);
    for (int i = 0; i < q.size(); i++)
      send_byte(q[i], !(bad_last && i == q.size() - 1));
    repeat (10) @(negedge clk);
  endtask

  // reference: interpret a byte list from the packet rules
  function automatic res_t model(input bq_t q,
                                 input logic [7:0] exp_id);
    res_t r;
    int i;
    int len;
    logic [7:0] sum;
    r = '{kind: 0, id: 0, err: 0, par: 0, np: 0};
    i = 2;
    while (i < q.size() && q[i] == 8'hFF) i++;
    r.id = q[i];
    len = int'(q[i+1]);
    if (len < 2 || len > 6) begin
      r.kind = 3;
      return r;
    end
    r.err = q[i+2];
    sum = r.id + 8'(len) + r.err;
    for (int p = 0; p < len - 2; p++) begin
      r.par[8*p +: 8] = q[i+3+p];
      sum = sum + q[i+3+p];
    end
    r.np = 3'(len - 2);
    if (q[i+len+1] == ~sum)
      r.kind = (r.id == exp_id) ? 1 : 0;
    else
      r.kind = 2;
    return r;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({status_valid, chk_err, pkt_err, timeout, busy} !== 5'b0) begin
      fails++;
      $display("FAIL reset_pulses: got %b want 00000",
               {status_valid, chk_err, pkt_err, timeout, busy});
    end
    checks++;
    if ({status_id, status_error, status_params, status_nparams}
        !== 51'd0) begin
      fails++;
      $display("FAIL reset_status: got %h %h %h %h want 0",
               status_id, status_error, status_params, status_nparams);
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_good();
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h00,
               8'h02, 8'hF8}, 1'b0);
    checks++;
    if (n_valid - v0 != 1 || n_chk != c0 || n_pkt != p0) begin
      fails++;
      $display("FAIL good_pulses: got v=%0d c=%0d p=%0d want 1 0 0",
               n_valid - v0, n_chk - c0, n_pkt - p0);
    end
    checks++;
    if (last_valid_cyc - last_start < LAT ||
        last_valid_cyc - last_start > LAT + 6) begin
      fails++;
      $display("FAIL good_latency: got %0d want %0d..%0d",
               last_valid_cyc - last_start, LAT, LAT + 6);
    end
    checks++;
    if ({status_id, status_error, status_params, status_nparams}
        !== {8'h01, 8'h00, 32'h0000_0200, 3'd2}) begin
      fails++;
      $display("FAIL good_status: got %h %h %h %0d want 01 00 00000200 2",
               status_id, status_error, status_params, status_nparams);
    end
    m_id = 8'h01; m_err = 8'h00; m_par = 32'h200; m_np = 3'd2;
  endtask

  task automatic test_bad_chk();
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h00,
               8'h02, 8'hF7}, 1'b0);
    checks++;
    if (n_chk - c0 != 1 || n_valid != v0) begin
      fails++;
      $display("FAIL badchk_pulses: got c=%0d v=%0d want 1 0",
               n_chk - c0, n_valid - v0);
    end
    checks++;
    if ({status_id, status_error, status_params, status_nparams}
        !== {m_id, m_err, m_par, m_np}) begin
      fails++;
      $display("FAIL badchk_hold: got %h %h %h want %h %h %h",
               status_id, status_error, status_params,
               m_id, m_err, m_par);
    end
  endtask

  task automatic test_id_filter();
    expected_id = 8'h01;
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'h02, 8'h04, 8'h00, 8'h00,
               8'h02, 8'hF7}, 1'b0);
    checks++;
    if (n_valid != v0 || n_chk != c0 || n_pkt != p0) begin
      fails++;
      $display("FAIL idfilt_pulses: got v=%0d c=%0d p=%0d want 0",
               n_valid - v0, n_chk - c0, n_pkt - p0);
    end
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00,
               8'h20, 8'hDB}, 1'b0);
    checks++;
    if (n_valid - v0 != 1) begin
      fails++;
      $display("FAIL preamble_valid: got %0d want 1", n_valid - v0);
    end
    checks++;
    if ({status_params, status_nparams} !== {32'h20, 3'd1}) begin
      fails++;
      $display("FAIL preamble_status: got %h %0d want 00000020 1",
               status_params, status_nparams);
    end
    m_id = 8'h01; m_err = 8'h00; m_par = 32'h20; m_np = 3'd1;
  endtask

  task automatic test_frame_err();
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'h01, 8'h03, 8'h00, 8'h20,
               8'hDB}, 1'b1);
    repeat (DIV) @(negedge clk);
    checks++;
    if (n_pkt - p0 != 1 || n_valid != v0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_err: got p=%0d v=%0d busy=%b want 1 0 0",
               n_pkt - p0, n_valid - v0, busy);
    end
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'h01, 8'h09}, 1'b0);
    checks++;
    if (n_pkt - p0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL len_err: got p=%0d busy=%b want 1 0",
               n_pkt - p0, busy);
    end
    checks++;
    if (last_pkt_cyc - last_start < LAT ||
        last_pkt_cyc - last_start > LAT + 6) begin
      fails++;
      $display("FAIL len_err_latency: got %0d want %0d..%0d",
               last_pkt_cyc - last_start, LAT, LAT + 6);
    end
  endtask

  task automatic test_timeout();
    int ts;
    int waited;
    snap();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    ts = last_start;
    waited = 0;
    while (n_to == t0 && waited < 6000) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (n_to - t0 != 1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL timeout_pulse: got t=%0d busy=%b want 1 0",
               n_to - t0, busy);
    end
    checks++;
    if (last_to_cyc - ts < LAT + 4995 ||
        last_to_cyc - ts > LAT + 5011) begin
      fails++;
      $display("FAIL timeout_latency: got %0d want about %0d",
               last_to_cyc - ts, LAT + 5003);
    end
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h00,
               8'h02, 8'hF8}, 1'b0);
    checks++;
    if (n_valid - v0 != 1 || status_params !== 32'h200) begin
      fails++;
      $display("FAIL after_timeout: got v=%0d par=%h want 1 00000200",
               n_valid - v0, status_params);
    end
    m_id = 8'h01; m_err = 8'h00; m_par = 32'h200; m_np = 3'd2;
  endtask

  task automatic test_gating();
    rx_enable = 1'b0;
    snap();
    send_pkt('{8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h00,
               8'h02, 8'hF8}, 1'b0);
    checks++;
    if (n_valid != v0 || n_chk != c0 || n_pkt != p0 ||
        n_to != t0 || n_busy != b0) begin
      fails++;
      $display("FAIL gating: got v=%0d c=%0d p=%0d t=%0d busy=%0d want 0",
               n_valid - v0, n_chk - c0, n_pkt - p0,
               n_to - t0, n_busy - b0);
    end
    rx_enable = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    snap();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({status_id, status_params, status_nparams, busy}
        !== 44'd0) begin
      fails++;
      $display("FAIL reset_mid_out: got %h %h %0d busy=%b want 0",
               status_id, status_params, status_nparams, busy);
    end
    reset = 1'b0;
    send_pkt('{8'h00, 8'h02, 8'hF8}, 1'b0);
    checks++;
    if (n_valid != v0 || n_chk != c0 || n_pkt != p0 ||
        n_to != t0) begin
      fails++;
      $display("FAIL reset_mid_pulses: got v=%0d c=%0d p=%0d t=%0d",
               n_valid - v0, n_chk - c0, n_pkt - p0, n_to - t0);
    end
    m_id = 0; m_err = 0; m_par = 0; m_np = 0;
  endtask

  task automatic test_random();
    bq_t q;
    res_t r;
    logic [7:0] id, len, sum, b;
    int np;
    for (int n = 0; n < 6; n++) begin
      q = {};
      q.push_back(8'hFF);
      q.push_back(8'hFF);
      for (int e = 0; e < int'($urandom_range(0, 1)); e++)
        q.push_back(8'hFF);
      id = 8'($urandom_range(0, 254));
      q.push_back(id);
      expected_id = ($urandom_range(0, 3) != 0) ? id : (id ^ 8'h01);
      if ($urandom_range(0, 7) == 0) begin
        len = 8'($urandom_range(7, 255));
        q.push_back(len);
      end else begin
        np = $urandom_range(0, 4);
        len = 8'(np + 2);
        q.push_back(len);
        b = 8'($urandom);
        q.push_back(b);
        sum = id + len + b;
        for (int p = 0; p < np; p++) begin
          b = 8'($urandom);
          q.push_back(b);
          sum = sum + b;
        end
        if ($urandom_range(0, 3) == 0)
          q.push_back(~sum ^ 8'($urandom_range(1, 255)));
        else
          q.push_back(~sum);
      end
      r = model(q, expected_id);
      snap();
      send_pkt(q, 1'b0);
      if (r.kind == 1) begin
        m_id = r.id; m_err = r.err; m_par = r.par; m_np = r.np;
      end
      checks++;
      if (n_valid - v0 != int'(r.kind == 1) ||
          n_chk - c0 != int'(r.kind == 2) ||
          n_pkt - p0 != int'(r.kind == 3)) begin
        fails++;
        $display("FAIL rand%0d_pulses: got v=%0d c=%0d p=%0d kind=%0d",
                 n, n_valid - v0, n_chk - c0, n_pkt - p0, r.kind);
      end
      checks++;
      if ({status_id, status_error, status_params, status_nparams}
          !== {m_id, m_err, m_par, m_np}) begin
        fails++;
        $display("FAIL rand%0d_status: got %h %h %h %0d want %h %h %h %0d",
                 n, status_id, status_error, status_params,
                 status_nparams, m_id, m_err, m_par, m_np);
      end
    end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad_chk();
    test_id_filter();
    test_frame_err();
    test_timeout();
    test_gating();
    test_reset_mid();
    test_random();
    checks++;
    if (n_multi != 0) begin
      fails++;
      $display("FAIL multi_err: got %0d cycles want 0", n_multi);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

  initial begin
    #(95000 * 20);
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dynamixel_status_rx.md
Name: dynamixel_status_rx

Overview:
- Receive side of the Dynamixel half-duplex bus.
- Deserialises 8N1 bytes from the servo's RXD line and parses Protocol 1.0 status packets: FF FF ID LEN ERR P0..Pn CHK.
- Verifies the checksum and presents the servo ID, error byte and up to four parameter bytes to the command FSM, which forwards them to the SPI read path.
- Sits downstream of the instruction-packet transmitter and consumes the servo's reply once the bus direction is released.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BAUD, 1000000, bus bit rate. The divider CLK_HZ/BAUD is an integer of at least 8.
- MAX_PARAMS, 4, maximum parameter bytes accepted (1..4).
- TIMEOUT_CYCLES, 5000, maximum idle clocks between bytes inside a packet.

Ports:
- clk  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- rxd  input  1  asynchronous serial data from the bus transceiver.
- rx_enable  input  1  1 = bus released to servo (listen); 0 = own transmission in progress (ignore).
- expected_id  input  8  ID of the servo whose reply is awaited.
- status_valid  output  1  one-cycle pulse: good packet from expected_id.
- status_id  output  8  ID field of the last good packet.
- status_error  output  8  ERR field of the last good packet.
- status_params  output  32  parameters of the last good packet, little-endian (P0 in [7:0]); unused bytes are 0.
- status_nparams  output  3  number of parameters (LEN-2).
- chk_err  output  1  one-cycle pulse: checksum mismatch.
- pkt_err  output  1  one-cycle pulse: framing error or illegal LEN.
- timeout  output  1  one-cycle pulse: inter-byte timeout inside a packet.
- busy  output  1  high while the parser is in any state other than HDR1.

Behaviour:
- Reset: all outputs 0; parser in HDR1; UART RX idle.
- Reset mid-packet discards the packet with no pulses.

UART RX:
- rxd passes through a 2-flop synchroniser.
- A falling edge while idle starts bit timing.
- Start bit is re-checked at half a bit period (DIV/2, DIV = CLK_HZ/BAUD). If it reads 1, the edge is a glitch and RX returns to idle.
- Data bits are sampled at mid-bit, LSB first.
- Stop bit sampled as 1: byte strobe is issued in that same cycle.
- Stop bit sampled as 0: pkt_err pulse, byte discarded, parser goes to HDR1.

rx_enable:
- While 0, UART RX is held idle and the parser is forced to HDR1. No pulses are produced.
- A byte in flight when rx_enable falls is dropped silently.

Parser FSM (advances only on a byte strobe):
- HDR1: FF -> HDR2; any other byte stays in HDR1.
- HDR2: FF -> ID; any other byte -> HDR1.
- ID: FF stays in ID (extra preamble). Any other byte is latched -> LEN.
- LEN: value in 2..MAX_PARAMS+2 -> ERR. Otherwise pkt_err pulse -> HDR1.
- ERR: latch; -> PARAM if LEN>2, else -> CHK.
- PARAM: store byte at index k; -> CHK after LEN-2 bytes.
- CHK: compare against the computed checksum (see below), then -> HDR1.

Checksum:
- Running 8-bit sum of ID, LEN, ERR and all parameters, mod 256.
- Expected CHK = ~sum[7:0].

Packet completion:
- Checksum match and ID == expected_id: status_id, status_error, status_params and status_nparams update and status_valid pulses. Both occur exactly 1 clk after the CHK stop-bit sample cycle.
- Checksum match and ID != expected_id: packet discarded with no pulse.
- Checksum mismatch: chk_err pulse at the same latency, regardless of ID. Status outputs are unchanged.
- Status outputs hold their values until the next good packet.

Timeout:
- An idle counter runs while busy and no byte is in flight, and clears on each byte strobe.
- When it reaches TIMEOUT_CYCLES: timeout pulse, parser -> HDR1.

Simultaneous events:
- At most one error pulse per cycle.
- Framing error takes priority over length error, which takes priority over timeout.

Optional Feature:
- Macro: DXL_RX_STATS_EN.
- Defined: adds output ports good_cnt[15:0] and err_cnt[15:0].
  - good_cnt increments on each status_valid.
  - err_cnt increments on each chk_err, pkt_err or timeout pulse.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Good 2-param packet: rx_enable=1, expected_id=01, bytes FF FF 01 04 00 00 02 F8 at 1 Mbaud -> status_valid 1 clk after the CHK stop sample; status_id=01, status_error=00, status_params=32'h0000_0200, status_nparams=2.
- Bad checksum: FF FF 01 04 00 00 02 F7 -> chk_err pulse, no status_valid, status outputs keep their previous values.
- ID filter and extra preamble:
  - expected_id=01, bytes FF FF 02 04 00 00 02 F7 -> no pulses.
  - Then FF FF FF 01 03 00 20 DB -> status_valid, status_params=32'h0000_0020, status_nparams=1.
- Framing/length errors:
  - CHK byte sent with stop bit 0 -> pkt_err, parser back in HDR1.
  - FF FF 01 09 ... -> pkt_err at the LEN byte.
- Timeout: FF FF 01 then idle for 5000 clks -> timeout pulse, busy falls. A following good packet is accepted.
- Direction gating and reset:
  - rx_enable=0 while a full good packet is sent -> no pulses, busy stays 0.
  - reset asserted after the ERR byte of a packet -> all outputs 0, no pulse for that packet.
